wb_cmd_initiator: RTL

Wishbone B4 pipelined initiator driven by a byte-wide command stream. It sits between the MCU-facing SPI byte deserializer and the `system` Wishbone peripheral port. It decodes read/write commands with a 20-bit address, issues one single-beat Wishbone transaction per command, and returns read data on a byte-wide response stream. It keeps an auto-incrementing address for streaming access, and provides a stall/ack timeout with a sticky error flag.

---
 rtl/wb_cmd_initiator.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_initiator.sv
// Byte-stream command decoder driving a single-beat Wishbone B4 pipelined initiator.
// Holds an auto-incrementing address, read response stream, and a stall/ack timeout.
module wb_cmd_initiator #(
    parameter int unsigned WB_ADDR_WIDTH  = 20,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_n_i,
    input  logic [7:0]               cmd_data_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    output logic [DATA_WIDTH-1:0]    rsp_data_o,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    input  logic                     wb_stall_i,
    input  logic                     wb_ack_i,
    output logic                     busy_o,
    output logic                     err_o,
    input  logic                     err_clear_i
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StHdr,
        StAddr1,
        StAddr0,
        StData,
        StReq,
        StWait,
        StRsp
    } state_e;

    state_e                   state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;
    logic                     err_q, err_d;
    logic                     cmd_ready_q, cyc_q, stb_q, rsp_valid_q, busy_q;
    logic                     accept, done, expired, err_set;

    assign accept = cmd_valid_i && cmd_ready_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = '0;
        err_set = 1'b0;
        done    = 1'b0;
        expired = 1'b0;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    case (cmd_data_i[7:4])
                        4'h1: begin
                            addr_d[19:16] = cmd_data_i[3:0];
                            we_d          = 1'b1;
                            state_d       = StAddr1;
                        end
                        4'h2: begin
                            addr_d[19:16] = cmd_data_i[3:0];
                            we_d          = 1'b0;
                            state_d       = StAddr1;
                        end
                        4'h3: begin
                            if (cmd_data_i[3:0] == 4'h0) begin
                                we_d    = 1'b1;
                                state_d = StData;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        4'h4: begin
                            if (cmd_data_i[3:0] == 4'h0) begin
                                we_d    = 1'b0;
                                state_d = StReq;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        default: err_set = 1'b1;
                    endcase
                end
            end
            StAddr1: begin
                if (accept) begin
                    addr_d[15:8] = cmd_data_i;
                    state_d      = StAddr0;
                end
            end
            StAddr0: begin
                if (accept) begin
                    addr_d[7:0] = cmd_data_i;
                    state_d     = we_q ? StData : StReq;
                end
            end
            StData: begin
                if (accept) begin
                    wdata_d = cmd_data_i[DATA_WIDTH-1:0];
                    state_d = StReq;
                end
            end
            StReq: begin
                // Ack only counts on the edge that also accepts the strobe.
                if (!wb_stall_i && wb_ack_i) begin
                    done = 1'b1;
                end else if (tmo_q == TmoLast) begin
                    expired = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                    if (!wb_stall_i) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (wb_ack_i) begin
                    done = 1'b1;
                end else if (tmo_q == TmoLast) begin
                    expired = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StRsp: begin
                if (rsp_ready_i) begin
                    state_d = StHdr;
                end
            end
            default: state_d = StHdr;
        endcase

        if (done) begin
            addr_d = addr_q + WB_ADDR_WIDTH'(1);
            if (we_q) begin
                state_d = StHdr;
            end else begin
                rdata_d = wb_data_i;
                state_d = StRsp;
            end
        end

        // The address is deliberately left alone so a retry hits the same location.
        if (expired) begin
            err_set = 1'b1;
            if (we_q) begin
                state_d = StHdr;
            end else begin
                rdata_d = {DATA_WIDTH{1'b1}};
                state_d = StRsp;
            end
        end

        err_d = err_set | (err_q & ~err_clear_i);
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q     <= StHdr;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == StHdr) || (state_d == StAddr1) ||
                           (state_d == StAddr0) || (state_d == StData);
            cyc_q       <= (state_d == StReq) || (state_d == StWait);
            stb_q       <= (state_d == StReq);
            rsp_valid_q <= (state_d == StRsp);
            busy_q      <= (state_d != StHdr);
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_data_o  = rdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_we_o     = we_q;
    assign wb_cycle_o  = cyc_q;
    assign wb_strobe_o = stb_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
